alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: in_instr  in  16  instruction, [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4, [7:0] imm8.
REQ-004 SHALL have ports: in_vld  in  1 / in_rdy  out  1  decode-to-issue handshake; transfer when both high.
REQ-005 SHALL have ports: rf_addr0, rf_addr1  out  4  register-file read addresses, combinational from in_instr.
REQ-006 SHALL have ports: rf_data0, rf_data1  in  16  same-cycle register-file read data.
REQ-007 SHALL have ports: src0, src1  out  16; shamt  out  4; func  out  3; paddsb, llb  out  1  registered ALU controls.
REQ-008 SHALL have ports: ex_vld  out  1 / ex_rdy  in  1  issue-to-writeback handshake; ex_rd  out  4; ex_we, ex_mem_rd, ex_mem_wr  out  1; ex_st_data  out  16.
REQ-009 SHALL have ports: alu_dst  in  16; alu_ov, alu_zr, alu_neg  in  1  combinational ALU results for the op held in EX.
REQ-010 SHALL have ports: flush  in  1  kill EX contents; flags  out  3  {V,Z,N} flag register.

Function
REQ-011 Opcodes 0000-0111 SHALL issue func=opcode[2:0], src0=R[rs], src1=R[rt], ex_we=1; paddsb=1 only for 0001.
REQ-012 Shifts (0101-0111) SHALL drive shamt=imm4; all other ops SHALL drive shamt=0.
REQ-013 LW (1000) SHALL issue func=000, src0=R[rs], src1=sign-extended imm4, ex_mem_rd=1, ex_we=1.
REQ-014 SW (1001) SHALL issue as LW address calc with ex_mem_wr=1, ex_we=0, rf_addr1=rd, ex_st_data=R[rd].
REQ-015 LLB (1011) SHALL issue func=000, llb=1, src0=0, src1=sign-extended imm8, ex_we=1.
REQ-016 Opcodes 1010, 1100-1111 SHALL issue as bubble-equivalent: ex_vld=1, ex_we=ex_mem_rd=ex_mem_wr=0, no flag update.
REQ-017 EX register SHALL load on in_vld&&in_rdy; latency decode-to-EX is exactly 1 cycle.
REQ-018 in_rdy SHALL equal (!ex_vld || ex_rdy) && !hazard_stall; ex_vld drops when EX retires with no new load.
REQ-019 When ex_vld&&!ex_rdy, all EX outputs SHALL hold stable.
REQ-020 flush SHALL clear ex_vld on the next edge, taking priority over a simultaneous load; flagged op SHALL not update flags.
REQ-021 Flags SHALL update on retire (ex_vld&&ex_rdy&&!flush): ADD/PADDSB/SUB write V,Z,N; AND/NOR/shifts write Z only; others none.

Reset
REQ-022 On rst_n=0: ex_vld=0, flags=000, src0=src1=0, func=0, shamt=0, paddsb=llb=0, ex_rd=0, ex_we=ex_mem_rd=ex_mem_wr=0, ex_st_data=0.
REQ-023 Reset mid-handshake SHALL discard the EX op; in_rdy SHALL be 1 the cycle after rst_n rises.

Configuration
REQ-024 With ALU_ISSUE_FWD_EN defined: when ex_vld&&ex_we&&!ex_mem_rd and ex_rd (nonzero) matches a read address, alu_dst SHALL replace that operand; hazard_stall=0 except LW-use, which stalls until retire.
REQ-025 Without ALU_ISSUE_FWD_EN: any such RAW match with ex_vld&&ex_we (ex_rd nonzero) SHALL assert hazard_stall until EX retires.
REQ-026 Register 0 SHALL never be a hazard or forwarding source in either build.

Structure
REQ-027 Shared package SHALL hold opcode constants, func encodings (ADD..SRA), flag bit indices V=2, Z=1, N=0.
REQ-028 Combinational decode SHALL be sub-module alu_issue_dec; pipeline, hazard and flag logic stay in alu_issue.

Verification
REQ-029 ADD R3,R1,R2 with R1=0x7FFF, R2=0x0001, alu_ov=1, alu_neg=1 -> next cycle src0=0x7FFF, src1=0x0001, func=000; flags=101 after retire.
REQ-030 ex_rdy=0 for 3 cycles with in_vld=1 -> in_rdy=0, EX outputs stable, flags unchanged; retire on 4th cycle.
REQ-031 LW offset imm4=0xF -> src1=0xFFFF, ex_mem_rd=1; dependent ADD next -> in_rdy=0 one cycle in both builds.
REQ-032 ADD R4 then AND R5,R4,R4 back-to-back -> FWD build: src0=src1=alu_dst, no stall; non-FWD: one stall cycle.
REQ-033 flush and in_vld/in_rdy same cycle -> ex_vld=0 next cycle, flags unchanged.
REQ-034 rst_n=0 while ex_vld=1 -> all REQ-022 values next cycle, flags=000.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared opcodes, ALU function codes, flag bit positions and the decoded-op / EX-stage
// records used by alu_issue and alu_issue_dec.
package alu_issue_pkg;
   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_PADDSB = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_AND    = 4'b0011;
   localparam logic [3:0] OP_NOR    = 4'b0100;
   localparam logic [3:0] OP_SLL    = 4'b0101;
   localparam logic [3:0] OP_SRL    = 4'b0110;
   localparam logic [3:0] OP_SRA    = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1011;

   typedef enum logic [2:0] {
      FUNC_ADD, FUNC_PADDSB, FUNC_SUB, FUNC_AND, FUNC_NOR, FUNC_SLL, FUNC_SRL, FUNC_SRA
   } func_e;

   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef enum logic [1:0] {SRC1_REG, SRC1_IMM4, SRC1_IMM8, SRC1_ZERO} src1_sel_e;

   typedef struct packed {
      func_e       func;
      logic        paddsb;
      logic        llb;
      logic [3:0]  shamt;
      logic [3:0]  rd;
      logic        we;
      logic        mem_rd;
      logic        mem_wr;
      logic        use0;
      logic        use1;
      logic        src0_zero;
      src1_sel_e   src1_sel;
      logic        upd_vn;
      logic        upd_z;
   } dec_t;

   typedef struct packed {
      logic [15:0] src0;
      logic [15:0] src1;
      logic [3:0]  shamt;
      func_e       func;
      logic        paddsb;
      logic        llb;
      logic [3:0]  rd;
      logic        we;
      logic        mem_rd;
      logic        mem_wr;
      logic [15:0] st_data;
      logic        upd_vn;
      logic        upd_z;
   } ex_t;

   function automatic logic [15:0] sext4(input logic [3:0] v);
      return {{12{v[3]}}, v};
   endfunction

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction
endpackage

// File: rtl/alu_issue_dec.sv
// Combinational instruction decode: register-file read addresses plus the control
// record that the issue stage captures into EX.
module alu_issue_dec
   import alu_issue_pkg::*;
(
   input  logic [15:0] instr_i,
   output logic [3:0]  rf_addr0_o,
   output logic [3:0]  rf_addr1_o,
   output dec_t        dec_o
);
   logic [3:0] opcode;
   assign opcode = instr_i[15:12];

   always_comb begin
      dec_o           = '0;
      dec_o.rd        = instr_i[11:8];
      dec_o.src0_zero = 1'b1;
      dec_o.src1_sel  = SRC1_ZERO;
      rf_addr0_o      = instr_i[7:4];
      rf_addr1_o      = instr_i[3:0];
      case (opcode)
         OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: begin
            dec_o.func      = func_e'(opcode[2:0]);
            dec_o.paddsb    = (opcode == OP_PADDSB);
            dec_o.shamt     = (opcode inside {OP_SLL, OP_SRL, OP_SRA}) ? instr_i[3:0] : 4'd0;
            dec_o.we        = 1'b1;
            dec_o.use0      = 1'b1;
            dec_o.use1      = 1'b1;
            dec_o.src0_zero = 1'b0;
            dec_o.src1_sel  = SRC1_REG;
            dec_o.upd_vn    = (opcode inside {OP_ADD, OP_PADDSB, OP_SUB});
            dec_o.upd_z     = 1'b1;
         end
         OP_LW: begin
            dec_o.we        = 1'b1;
            dec_o.mem_rd    = 1'b1;
            dec_o.use0      = 1'b1;
            dec_o.src0_zero = 1'b0;
            dec_o.src1_sel  = SRC1_IMM4;
         end
         OP_SW: begin
            // Store data comes through read port 1, so it reads rd instead of rt.
            rf_addr1_o      = instr_i[11:8];
            dec_o.mem_wr    = 1'b1;
            dec_o.use0      = 1'b1;
            dec_o.use1      = 1'b1;
            dec_o.src0_zero = 1'b0;
            dec_o.src1_sel  = SRC1_IMM4;
         end
         OP_LLB: begin
            dec_o.llb       = 1'b1;
            dec_o.we        = 1'b1;
            dec_o.src1_sel  = SRC1_IMM8;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: single EX register with valid/ready handshakes, RAW hazard stall and
// {V,Z,N} flag register. Define ALU_ISSUE_FWD_EN to bypass alu_dst into operands.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_instr,
   input  logic        in_vld,
   output logic        in_rdy,
   output logic [3:0]  rf_addr0,
   output logic [3:0]  rf_addr1,
   input  logic [15:0] rf_data0,
   input  logic [15:0] rf_data1,
   output logic [15:0] src0,
   output logic [15:0] src1,
   output logic [3:0]  shamt,
   output logic [2:0]  func,
   output logic        paddsb,
   output logic        llb,
   output logic        ex_vld,
   input  logic        ex_rdy,
   output logic [3:0]  ex_rd,
   output logic        ex_we,
   output logic        ex_mem_rd,
   output logic        ex_mem_wr,
   output logic [15:0] ex_st_data,
   input  logic [15:0] alu_dst,
   input  logic        alu_ov,
   input  logic        alu_zr,
   input  logic        alu_neg,
   input  logic        flush,
   output logic [2:0]  flags
);
   dec_t        dec;
   ex_t         ex_q, ex_d;
   logic        ex_vld_q, ex_vld_d;
   logic [2:0]  flags_q, flags_d;
   logic        wr_pending, match0, match1, fwd0, fwd1, hazard_stall, load, retire;
   logic [15:0] op0, op1;

   alu_issue_dec u_dec (
      .instr_i    (in_instr),
      .rf_addr0_o (rf_addr0),
      .rf_addr1_o (rf_addr1),
      .dec_o      (dec)
   );

   assign wr_pending = ex_vld_q && ex_q.we && (ex_q.rd != 4'd0);
   assign match0     = wr_pending && dec.use0 && (rf_addr0 == ex_q.rd);
   assign match1     = wr_pending && dec.use1 && (rf_addr1 == ex_q.rd);

`ifdef ALU_ISSUE_FWD_EN
   // A load's data is not on alu_dst, so only load-use still has to wait.
   assign fwd0         = match0 && !ex_q.mem_rd;
   assign fwd1         = match1 && !ex_q.mem_rd;
   assign hazard_stall = (match0 || match1) && ex_q.mem_rd;
`else
   assign fwd0         = 1'b0;
   assign fwd1         = 1'b0;
   assign hazard_stall = match0 || match1;
`endif

   assign in_rdy = (!ex_vld_q || ex_rdy) && !hazard_stall;
   assign load   = in_vld && in_rdy;
   assign retire = ex_vld_q && ex_rdy && !flush;
   assign op0    = fwd0 ? alu_dst : rf_data0;
   assign op1    = fwd1 ? alu_dst : rf_data1;

   always_comb begin
      ex_vld_d = ex_vld_q;
      ex_d     = ex_q;
      flags_d  = flags_q;
      if (retire) begin
         if (ex_q.upd_vn) begin
            flags_d[FLAG_V] = alu_ov;
            flags_d[FLAG_Z] = alu_zr;
            flags_d[FLAG_N] = alu_neg;
         end else if (ex_q.upd_z) begin
            flags_d[FLAG_Z] = alu_zr;
         end
      end
      if (ex_vld_q && ex_rdy) ex_vld_d = 1'b0;
      if (flush) begin
         ex_vld_d = 1'b0;
      end else if (load) begin
         ex_vld_d     = 1'b1;
         ex_d.src0    = dec.src0_zero ? 16'd0 : op0;
         case (dec.src1_sel)
            SRC1_REG:  ex_d.src1 = op1;
            SRC1_IMM4: ex_d.src1 = sext4(in_instr[3:0]);
            SRC1_IMM8: ex_d.src1 = sext8(in_instr[7:0]);
            default:   ex_d.src1 = 16'd0;
         endcase
         ex_d.shamt   = dec.shamt;
         ex_d.func    = dec.func;
         ex_d.paddsb  = dec.paddsb;
         ex_d.llb     = dec.llb;
         ex_d.rd      = dec.rd;
         ex_d.we      = dec.we;
         ex_d.mem_rd  = dec.mem_rd;
         ex_d.mem_wr  = dec.mem_wr;
         ex_d.st_data = dec.mem_wr ? op1 : 16'd0;
         ex_d.upd_vn  = dec.upd_vn;
         ex_d.upd_z   = dec.upd_z;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_vld_q <= 1'b0;
         ex_q     <= '0;
         flags_q  <= 3'b000;
      end else begin
         ex_vld_q <= ex_vld_d;
         ex_q     <= ex_d;
         flags_q  <= flags_d;
      end
   end

   assign ex_vld     = ex_vld_q;
   assign src0       = ex_q.src0;
   assign src1       = ex_q.src1;
   assign shamt      = ex_q.shamt;
   assign func       = ex_q.func;
   assign paddsb     = ex_q.paddsb;
   assign llb        = ex_q.llb;
   assign ex_rd      = ex_q.rd;
   assign ex_we      = ex_q.we;
   assign ex_mem_rd  = ex_q.mem_rd;
   assign ex_mem_wr  = ex_q.mem_wr;
   assign ex_st_data = ex_q.st_data;
   assign flags      = flags_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios then random traffic, all checked against an
// instruction-level model of the issue slot and flag register.
module tb_alu_issue;
   logic        clk = 1'b0;
   logic        rst_n, in_vld, in_rdy, ex_vld, ex_rdy, flush;
   logic [15:0] in_instr, rf_data0, rf_data1, src0, src1, ex_st_data, alu_dst;
   logic [3:0]  rf_addr0, rf_addr1, shamt, ex_rd;
   logic [2:0]  func, flags;
   logic        paddsb, llb, ex_we, ex_mem_rd, ex_mem_wr, alu_ov, alu_zr, alu_neg;
   logic [15:0] rf [16];

   always #5 clk = ~clk;

   assign rf_data0 = rf[rf_addr0];
   assign rf_data1 = rf[rf_addr1];

   alu_issue dut (
      .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_vld(in_vld), .in_rdy(in_rdy),
      .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_data0(rf_data0), .rf_data1(rf_data1),
      .src0(src0), .src1(src1), .shamt(shamt), .func(func), .paddsb(paddsb), .llb(llb),
      .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .ex_st_data(ex_st_data), .alu_dst(alu_dst), .alu_ov(alu_ov),
      .alu_zr(alu_zr), .alu_neg(alu_neg), .flush(flush), .flags(flags)
   );

   typedef struct packed {
      logic        vld;
      logic [15:0] src0, src1, st;
      logic [3:0]  shamt, rd;
      logic [2:0]  func;
      logic        paddsb, llb, we, mrd, mwr;
      logic [1:0]  fclass;   // 2: writes V,Z,N  1: writes Z  0: none
   } exp_t;

   exp_t       m;
   logic [2:0] m_flags;
   bit         fwd_en, last_acc;
   int         checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads(input logic [15:0] ins, input logic [3:0] r);
      logic [3:0] op;
      op = ins[15:12];
      if (op <= 4'd7) return (r == ins[7:4]) || (r == ins[3:0]);
      if (op == 4'd8) return r == ins[7:4];
      if (op == 4'd9) return (r == ins[7:4]) || (r == ins[11:8]);
      return 1'b0;
   endfunction

   function automatic logic [15:0] rd_val(input logic [3:0] r);
      if (fwd_en && m.vld && m.we && !m.mrd && m.rd != 4'd0 && r == m.rd) return alu_dst;
      return rf[r];
   endfunction

   function automatic exp_t issue(input logic [15:0] ins);
      exp_t e;
      logic [3:0] op, rd, rs, rt;
      op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
      e = '0;
      e.vld = 1'b1;
      e.rd  = rd;
      if (op <= 4'd7) begin
         e.func = op[2:0]; e.src0 = rd_val(rs); e.src1 = rd_val(rt); e.we = 1'b1;
         e.paddsb = (op == 4'd1);
         e.shamt  = (op >= 4'd5) ? rt : 4'd0;
         e.fclass = (op <= 4'd2) ? 2'd2 : 2'd1;
      end else if (op == 4'd8) begin
         e.src0 = rd_val(rs); e.src1 = 16'($signed(rt)); e.we = 1'b1; e.mrd = 1'b1;
      end else if (op == 4'd9) begin
         e.src0 = rd_val(rs); e.src1 = 16'($signed(rt)); e.mwr = 1'b1; e.st = rd_val(rd);
      end else if (op == 4'd11) begin
         e.llb = 1'b1; e.we = 1'b1; e.src1 = 16'($signed(ins[7:0]));
      end
      return e;
   endfunction

   task automatic cycle(input string tag);
      exp_t        nx;
      logic [2:0]  nf;
      logic [15:0] ins;
      bit          pend, stall, rdy_e, full, acc;
      @(negedge clk);
      ins   = in_instr;
      pend  = m.vld && m.we && (m.rd != 4'd0);
      stall = pend && reads(ins, m.rd) && (!fwd_en || m.mrd);
      rdy_e = (!m.vld || ex_rdy) && !stall;
      check({tag, ".in_rdy"}, 32'(in_rdy), 32'(rdy_e));
      check({tag, ".rf_addr0"}, 32'(rf_addr0), 32'(ins[7:4]));
      check({tag, ".rf_addr1"}, 32'(rf_addr1), 32'((ins[15:12] == 4'd9) ? ins[11:8] : ins[3:0]));
      nx = m; nf = m_flags; full = !rst_n; acc = 1'b0;
      last_acc = in_vld && rdy_e;
      if (!rst_n) begin
         nx = '0; nf = 3'b000;
      end else begin
         if (m.vld && ex_rdy && !flush) begin
            if (m.fclass == 2'd2) nf = {alu_ov, alu_zr, alu_neg};
            else if (m.fclass == 2'd1) nf[1] = alu_zr;
         end
         if (m.vld && ex_rdy) nx.vld = 1'b0;
         if (flush) nx.vld = 1'b0;
         else if (in_vld && rdy_e) begin nx = issue(ins); acc = 1'b1; end
      end
      @(posedge clk); #1;
      m = nx; m_flags = nf;
      if (acc) $display("[%0t] %s issue instr=%04h src0=%04h src1=%04h", $time, tag, ins, m.src0, m.src1);
      check({tag, ".ex_vld"}, 32'(ex_vld), 32'(m.vld));
      check({tag, ".flags"}, 32'(flags), 32'(m_flags));
      if (m.vld || full) begin
         check({tag, ".src0"}, 32'(src0), 32'(m.src0));
         check({tag, ".src1"}, 32'(src1), 32'(m.src1));
         check({tag, ".shamt"}, 32'(shamt), 32'(m.shamt));
         check({tag, ".func"}, 32'(func), 32'(m.func));
         check({tag, ".ctl"}, 32'({paddsb, llb, ex_we, ex_mem_rd, ex_mem_wr}),
               32'({m.paddsb, m.llb, m.we, m.mrd, m.mwr}));
         check({tag, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
         check({tag, ".st_data"}, 32'(ex_st_data), 32'(m.st));
      end
   endtask

   task automatic drive(input logic [15:0] ins, input logic vld, input logic rdy, input logic fl);
      in_instr = ins; in_vld = vld; ex_rdy = rdy; flush = fl;
   endtask

   task automatic set_alu(input logic [15:0] d, input logic ov, input logic zr, input logic ng);
      alu_dst = d; alu_ov = ov; alu_zr = zr; alu_neg = ng;
   endtask

   initial begin
      logic [2:0] saved_flags;
`ifdef ALU_ISSUE_FWD_EN
      fwd_en = 1'b1;
`else
      fwd_en = 1'b0;
`endif
      for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
      rf[1] = 16'h7FFF; rf[2] = 16'h0001;
      m = '0; m_flags = 3'b000; last_acc = 1'b0;
      rst_n = 1'b0;
      drive(16'h0000, 1'b0, 1'b0, 1'b0);
      set_alu(16'h0000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      cycle("reset");
      rst_n = 1'b1;
      cycle("post_rst");

      // ADD R3,R1,R2 with overflow and negative result
      drive(16'h0312, 1'b1, 1'b1, 1'b0);
      cycle("add");
      check("add.src0_lit", 32'(src0), 32'h7FFF);
      check("add.src1_lit", 32'(src1), 32'h0001);
      check("add.func_lit", 32'(func), 32'h0);
      in_vld = 1'b0;
      set_alu(16'h8000, 1'b1, 1'b0, 1'b1);
      cycle("add_ret");
      check("add_ret.flags_lit", 32'(flags), 32'b101);

      // Backpressure: EX held three cycles, retires on the fourth
      drive(16'h0412, 1'b1, 1'b1, 1'b0);
      cycle("bp_load");
      drive(16'h2856, 1'b1, 1'b0, 1'b0);
      set_alu(16'h0000, 1'b0, 1'b1, 1'b0);
      repeat (3) cycle("bp_hold");
      check("bp_hold.flags_lit", 32'(flags), 32'b101);
      check("bp_hold.src0_lit", 32'(src0), 32'h7FFF);
      ex_rdy = 1'b1;
      cycle("bp_ret");
      check("bp_ret.flags_lit", 32'(flags), 32'b010);

      // LW with negative offset, then a dependent ADD
      drive(16'h861F, 1'b1, 1'b1, 1'b0);
      set_alu(16'h1234, 1'b0, 1'b0, 1'b0);
      cycle("lw");
      check("lw.src1_lit", 32'(src1), 32'hFFFF);
      check("lw.mem_rd_lit", 32'(ex_mem_rd), 32'h1);
      drive(16'h0762, 1'b1, 1'b1, 1'b0);
      cycle("lw_use");
      check("lw_use.stall_vld", 32'(ex_vld), 32'h0);
      cycle("lw_use2");
      check("lw_use2.src0", 32'(src0), 32'(rf[6]));

      // Back-to-back ADD R4 / AND R5,R4,R4
      set_alu(16'hBEEF, 1'b1, 1'b0, 1'b1);
      drive(16'h0412, 1'b1, 1'b1, 1'b0);
      cycle("raw_add");
      drive(16'h3544, 1'b1, 1'b1, 1'b0);
      cycle("raw_and");
`ifdef ALU_ISSUE_FWD_EN
      check("raw_and.fwd_src0", 32'(src0), 32'hBEEF);
      check("raw_and.fwd_src1", 32'(src1), 32'hBEEF);
`else
      check("raw_and.stall_vld", 32'(ex_vld), 32'h0);
      cycle("raw_and2");
      check("raw_and2.src0", 32'(src0), 32'(rf[4]));
`endif

      // flush together with a new transfer
      saved_flags = m_flags;
      set_alu(16'h0000, 1'b1, 1'b1, 1'b1);
      drive(16'h0112, 1'b1, 1'b1, 1'b1);
      cycle("flush");
      check("flush.vld_lit", 32'(ex_vld), 32'h0);
      check("flush.flags_kept", 32'(flags), 32'(saved_flags));
      flush = 1'b0;

      // reset while EX holds an op
      drive(16'h0912, 1'b1, 1'b1, 1'b0);
      set_alu(16'h4321, 1'b1, 1'b0, 1'b1);
      cycle("rst_load");
      rst_n = 1'b0;
      drive(16'h0A12, 1'b1, 1'b0, 1'b0);
      cycle("rst_mid");
      check("rst_mid.flags_lit", 32'(flags), 32'h0);
      check("rst_mid.vld_lit", 32'(ex_vld), 32'h0);
      rst_n = 1'b1;
      in_vld = 1'b0;
      cycle("rst_post");

      for (int n = 0; n < 400; n++) begin
         if (!(in_vld && !last_acc)) begin
            in_instr = 16'($urandom);
            if ($urandom_range(0, 4) != 0) begin
               in_instr[11:10] = 2'b00; in_instr[7:6] = 2'b00; in_instr[3:2] = 2'b00;
            end
            in_vld = ($urandom_range(0, 3) != 0);
         end
         ex_rdy = ($urandom_range(0, 9) < 7);
         flush  = ($urandom_range(0, 19) == 0);
         rst_n  = ($urandom_range(0, 99) != 0);
         alu_dst = 16'($urandom);
         {alu_ov, alu_zr, alu_neg} = 3'($urandom);
         if ($urandom_range(0, 31) == 0) rf[$urandom_range(0, 15)] = 16'($urandom);
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
